// File: rtl/soc_ram_stream_pkg.sv
// soc_ram_stream_pkg: shared FSM type, default widths and FIFO sizing
// helper for the RAM stream reader slice (abort option: SOC_RAM_STREAM_ABORT_EN).
package soc_ram_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int DEF_ADDR_W     = 14;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_CNT_W      = 15;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_RD_LAT     = 1;

   // Occupancy counter must hold 0..depth inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/soc_ram_stream_reader_if.sv
// Bus bundles for the RAM stream reader.
// soc_ram_mem_if:    Avalon-MM read port toward the RAM s2 slave.
//   master drives mem_address/chipselect/write/byteenable/clken,
//   slave returns mem_readdata.
// soc_ram_stream_if: valid/ready output stream.
//   master drives out_data/out_valid/out_last, slave returns out_ready.
interface soc_ram_mem_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_write;
   logic [3:0]        mem_byteenable;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   modport master (
      output mem_address,
      output mem_chipselect,
      output mem_write,
      output mem_byteenable,
      output mem_clken,
      input  mem_readdata
   );

   modport slave (
      input  mem_address,
      input  mem_chipselect,
      input  mem_write,
      input  mem_byteenable,
      input  mem_clken,
      output mem_readdata
   );
endinterface

interface soc_ram_stream_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/soc_ram_stream_fifo.sv
// soc_ram_stream_fifo: first-word-fall-through FIFO, power-of-2 depth.
// Ports: push_i/wdata_i, pop_i, flush_i in; rdata_o, count_o, full_o, empty_o out.
module soc_ram_stream_fifo
   import soc_ram_stream_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_FIFO_DEPTH,
   localparam int CW    = fifo_cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic [CW-1:0]     count_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == DEPTH_V);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      do_push = push_i && !full_o && !flush_i;
      do_pop  = pop_i && !empty_o && !flush_i;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/soc_ram_stream_reader.sv
// soc_ram_stream_reader: Avalon-MM block reader from on-chip RAM to a
// valid/ready stream with credit-limited issue.
// Ports: clk, reset_n; start/base_addr/word_count in, busy/done out;
// mem (soc_ram_mem_if.master), strm (soc_ram_stream_if.master).
// With SOC_RAM_STREAM_ABORT_EN: abort in, aborted out.
module soc_ram_stream_reader
   import soc_ram_stream_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int RD_LAT     = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
`ifdef SOC_RAM_STREAM_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   soc_ram_mem_if.master     mem,
   soc_ram_stream_if.master  strm
);

   localparam int CW = fifo_cnt_w(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  issue_q, issue_d;
   logic [CNT_W-1:0]  recv_q, recv_d;
   logic [RD_LAT-1:0] infl_q, infl_d;
   logic              done_q, done_d;

   logic              issue, push, pop, kill;
   logic [CW:0]       occ;
   logic [CW-1:0]     fifo_cnt;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;

`ifdef SOC_RAM_STREAM_ABORT_EN
   logic aborted_q;
   assign kill    = abort && busy;
   assign aborted = aborted_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) aborted_q <= 1'b0;
      else          aborted_q <= kill;
   end
`else
   assign kill = 1'b0;
`endif

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

   assign mem.mem_address    = addr_q;
   assign mem.mem_chipselect = issue;
   assign mem.mem_write      = 1'b0;
   assign mem.mem_byteenable = 4'hF;
   assign mem.mem_clken      = 1'b1;

   assign strm.out_data  = fifo_rdata;
   assign strm.out_valid = !fifo_empty;
   assign strm.out_last  = !fifo_empty && (recv_q == ONE);

   assign pop  = !fifo_empty && strm.out_ready;
   assign push = infl_q[RD_LAT-1] && !kill;

   // Words already committed: queued plus still in the RAM pipe.
   always_comb begin
      occ = {1'b0, fifo_cnt};
      for (int i = 0; i < RD_LAT; i++) begin
         occ = occ + {{CW{1'b0}}, infl_q[i]};
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      issue_d = issue_q;
      recv_d  = recv_q;
      done_d  = 1'b0;
      issue   = 1'b0;
      if (pop) recv_d = recv_q - 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  addr_d  = base_addr;
                  issue_d = word_count;
                  recv_d  = word_count;
                  state_d = ST_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (issue_q != '0 && occ < DEPTH_V) begin
               issue   = 1'b1;
               addr_d  = addr_q + 1'b1;
               issue_d = issue_q - 1'b1;
               if (issue_q == ONE) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && recv_q == ONE) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over everything, including a final pop.
      if (kill) begin
         issue   = 1'b0;
         addr_d  = addr_q;
         issue_d = issue_q;
         state_d = ST_IDLE;
         done_d  = 1'b1;
      end
   end

   always_comb begin
      infl_d    = '0;
      infl_d[0] = issue;
      for (int i = 1; i < RD_LAT; i++) begin
         infl_d[i] = infl_q[i-1];
      end
      if (kill) infl_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         issue_q <= '0;
         recv_q  <= '0;
         infl_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         issue_q <= issue_d;
         recv_q  <= recv_d;
         infl_q  <= infl_d;
         done_q  <= done_d;
      end
   end

   soc_ram_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .wdata_i (mem.mem_readdata),
      .pop_i   (pop),
      .flush_i (kill),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // The issue credit check makes a push into a full FIFO impossible.
   a_no_overflow: assert property (
      @(posedge clk) disable iff (!reset_n) !(push && fifo_full)
   );

endmodule

// File: doc/soc_ram_stream_reader.md
Name: soc_ram_stream_reader

Overview:
- Avalon-MM read master that sits directly upstream of the 16K x 32 on-chip RAM slave (s2 port).
- On a start command it reads a contiguous block of words, starting at base_addr, from the RAM.
- Read data is presented as a valid/ready stream to downstream consumers (sprite/tile fetch, DMA-to-peripheral).
- A credit-based issue scheme plus a small output FIFO guarantees no data loss under downstream backpressure.

Parameters:
- ADDR_W, 14, RAM word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, RAM data width.
- CNT_W, 15, width of word_count; allows a full-RAM transfer of 16384 words.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.
- RD_LAT, 1, fixed RAM read latency in cycles (address registered, q unregistered).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured on an accepted start.
- word_count  in  CNT_W  number of words to read; captured on an accepted start.
- busy  out  1  high from an accepted start until the done pulse.
- done  out  1  one-cycle pulse when the last word has been accepted downstream.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  read strobe; one read is issued per high cycle.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  RAM q; valid RD_LAT cycles after the issue cycle.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; transfer occurs when out_valid and out_ready are both high.
- out_last  out  1  high with the final word of the block.

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_last=0. The FIFO, counters and in-flight pipeline are cleared.
- Asynchronous reset mid-transfer aborts the transfer immediately; no done pulse is generated.
- State machine:
  - IDLE: start=1 with word_count!=0 captures addr, issue_cnt and recv_cnt, then goes to RUN.
  - IDLE: start=1 with word_count==0 pulses done on the next cycle, stays in IDLE, and issues no reads.
  - RUN: issues reads. When issue_cnt reaches 0, goes to DRAIN.
  - DRAIN: waits until recv_cnt reaches 0 (the last word has been popped), then pulses done and returns to IDLE.
- start is ignored while busy.
- Issue rule: mem_chipselect=1 in a cycle only if issue_cnt!=0 and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is a shift register of depth RD_LAT that tracks issued reads.
  - Back-to-back issues give 1 word/clk with out_ready held high.
- Address generation: mem_address increments by 1 after each issue and wraps from 2^ADDR_W-1 to 0.
- Capture: mem_readdata is written into the FIFO when inflight[RD_LAT-1]=1. Writes never find the FIFO full; this is an assertion.
- FIFO semantics:
  - out_valid = FIFO not empty; out_data = FIFO head (first-word fall-through).
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- out_last=1 when out_valid=1 and recv_cnt==1.
- done is asserted on the cycle after the final pop. busy deasserts in the same cycle that done is high.
- Latency: start accepted at cycle 0 → first issue at cycle 1 → first out_valid at cycle 1+RD_LAT+1 (registered FIFO write).

Optional Feature:
- Macro: SOC_RAM_STREAM_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 while busy stops issuing, flushes the FIFO, and discards in-flight returns.
  - Next cycle: done=1 and aborted=1 (one-cycle pulse), then return to IDLE.
  - abort in IDLE has no effect.
  - abort in the same cycle as the final pop takes priority: aborted=1.
- Without the macro: the ports and logic are absent, and behaviour is exactly as above.

Decomposition:
- Package soc_ram_stream_pkg holds:
  - state enum (ST_IDLE, ST_RUN, ST_DRAIN);
  - localparams for default ADDR_W, DATA_W, CNT_W;
  - the FIFO count width function (clog2(FIFO_DEPTH)+1).
- One sub-module, soc_ram_stream_fifo: synchronous FWFT FIFO with push, pop, flush, count, full and empty.

Test Plan:
- Basic block, no backpressure: RAM model preloaded with mem[i]=i. start with base=0x0010, count=8 and out_ready=1 → words 0x10..0x17 on consecutive cycles; out_last on 0x17; done pulses one cycle after; exactly 8 chipselects.
- Wrap-around: base=0x3FFE, count=4 → addresses issued 3FFE, 3FFF, 0000, 0001; data matches.
- Backpressure: count=16 with out_ready toggling 1-in-3 → all 16 words in order, no drops or duplicates, FIFO overflow assertion never fires, at most FIFO_DEPTH outstanding.
- word_count=0 → done one cycle after start, no chipselect, out_valid stays 0. A start received while busy is ignored; a second done never appears.
- Reset mid-transfer: reset_n low at word 5 of 10 → all outputs return to reset values asynchronously. After release the block is IDLE, and a new start (base=0, count=2) completes normally.
- Abort (SOC_RAM_STREAM_ABORT_EN): abort at word 3 of 12 with out_ready=0 → next cycle done=1 and aborted=1, out_valid=0, no further chipselect.
